// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the counter-stage reset sequencer.
// Holds the FSM state enum, default timing constants and reset_count sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_MANUAL = 2'd2
  } seq_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 8;

  localparam int                   RST_CNT_W   = 4;
  localparam logic [RST_CNT_W-1:0] RST_CNT_MAX = 4'd15;

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer with asynchronous active-low clear.
// Used both as a reset-release synchronizer (d tied high) and as a plain input synchronizer.
module sync_chain #(
  parameter int N = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[N-2:0], i_d};
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/reset_sequencer.sv
// Clean reset generator for the 5-bit counter stage: async assert from board reset,
// synchronous release after a hold period, plus a debounced push-button manual reset.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn,
  output logic                 counter_reset,
  output logic                 release_pulse,
  output logic [RST_CNT_W-1:0] reset_count
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic w_rst_sync;
  logic w_btn_sync;

  sync_chain #(.N(SYNC_STAGES)) u_rst_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (1'b1),
    .o_q     (w_rst_sync)
  );

  sync_chain #(.N(SYNC_STAGES)) u_btn_sync (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_d     (btn),
    .o_q     (w_btn_sync)
  );

  seq_state_e           r_state, w_state_nxt;
  logic [HOLD_W-1:0]    r_hold_cnt, w_hold_nxt;
  logic [DEB_W-1:0]     r_deb_cnt, w_deb_nxt;
  logic [RST_CNT_W-1:0] r_count, w_count_nxt;
  logic                 r_counter_reset, w_counter_reset_nxt;
  logic                 r_release_pulse, w_release_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_HOLD;
      r_hold_cnt      <= '0;
      r_deb_cnt       <= '0;
      r_count         <= '0;
      r_counter_reset <= 1'b1;
      r_release_pulse <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_hold_cnt      <= w_hold_nxt;
      r_deb_cnt       <= w_deb_nxt;
      r_count         <= w_count_nxt;
      r_counter_reset <= w_counter_reset_nxt;
      r_release_pulse <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold_cnt;
    w_deb_nxt     = r_deb_cnt;
    w_count_nxt   = r_count;
    w_release_nxt = 1'b0;
    case (r_state)
      ST_HOLD: begin
        // Button is ignored while holding; the debounce count stays parked at zero.
        w_deb_nxt = '0;
        if (w_rst_sync) begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt   = ST_RUN;
            w_hold_nxt    = '0;
            w_release_nxt = 1'b1;
          end else begin
            w_hold_nxt = r_hold_cnt + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (!w_btn_sync) begin
          w_deb_nxt = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = ST_MANUAL;
          w_deb_nxt   = '0;
          if (r_count != RST_CNT_MAX) w_count_nxt = r_count + 1'b1;
        end else begin
          w_deb_nxt = r_deb_cnt + 1'b1;
        end
      end
      ST_MANUAL: begin
        if (w_btn_sync) begin
          w_deb_nxt = '0;
        end else if (r_deb_cnt == DEB_LAST) begin
          w_state_nxt = ST_HOLD;
          w_deb_nxt   = '0;
        end else begin
          w_deb_nxt = r_deb_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_hold_nxt  = '0;
        w_deb_nxt   = '0;
      end
    endcase
    w_counter_reset_nxt = (w_state_nxt != ST_RUN);
  end

  // The output flop is async-set by reset, giving the immediate assertion path.
  assign counter_reset = r_counter_reset;
  assign release_pulse = r_release_pulse;
  assign reset_count   = r_count;

endmodule
